// File: rtl/msg_scroller.sv
// ---------------------------------------------------------------------------
// msg_scroller
//
// Scrolls a MSG_NIBBLES-digit hex message through a WIN_NIBBLES-digit window
// on the display data bus, one nibble per enabled clk3hz edge. Two modes:
//   circular : endless rotation, direction chosen live by dir
//   bounce   : ping-pong between offset 0 and LAST, holding DWELL run cycles
//              at each end
//
// Ports
//   clk3hz   in   scroll clock, rising edge
//   rst      in   synchronous reset, active low
//   msg_in   in   message, nibble MSG_NIBBLES-1 shown first
//   load     in   synchronous reload of msg_in and mode
//   run      in   scroll enable, low freezes all state
//   mode     in   0 = circular, 1 = bounce (latched at reset/load only)
//   dir      in   circular direction, 0 = left, 1 = right
//   dataBus  out  top WIN_NIBBLES nibbles of the rotation register
//   offset   out  net left-rotation count, modulo MSG_NIBBLES
//   edge_p   out  one-cycle pulse at a wrap (circular) or end (bounce)
//   dbgState out  bounce FSM state (FWD=0, DW_END=1, BACK=2, DW_START=3)
//
// Handshake: none. load and run are level-sampled enables; priority is
// !rst > load > run > hold, and every output comes straight from a register.
// ---------------------------------------------------------------------------
module msg_scroller #(
    parameter int MSG_NIBBLES = 8,
    parameter int WIN_NIBBLES = 4,
    parameter int DWELL       = 2,
    parameter int OFFW        = ($clog2(MSG_NIBBLES) < 1) ? 1 : $clog2(MSG_NIBBLES)
) (
    input  logic                     clk3hz,
    input  logic                     rst,
    input  logic [4*MSG_NIBBLES-1:0] msg_in,
    input  logic                     load,
    input  logic                     run,
    input  logic                     mode,
    input  logic                     dir,
    output logic [4*WIN_NIBBLES-1:0] dataBus,
    output logic [OFFW-1:0]          offset,
    output logic                     edge_p,
    output logic [1:0]               dbgState
);

    typedef enum logic [1:0] {
        FWD      = 2'd0,
        DW_END   = 2'd1,
        BACK     = 2'd2,
        DW_START = 2'd3
    } stateT;

    localparam int MW  = 4 * MSG_NIBBLES;
    localparam int DWW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    localparam logic [OFFW-1:0] OFF_MAX  = OFFW'(MSG_NIBBLES - 1);
    localparam logic [OFFW-1:0] LAST_OFF = OFFW'(MSG_NIBBLES - WIN_NIBBLES);
    localparam logic [DWW-1:0]  DW_LAST  = DWW'((DWELL > 0) ? DWELL - 1 : 0);

    logic [MW-1:0]   rot;
    logic            modeQ;
    stateT           state;
    logic [DWW-1:0]  dwellCnt;

    logic [MW-1:0]   rotL;
    logic [MW-1:0]   rotR;
    logic [OFFW-1:0] offInc;
    logic [OFFW-1:0] offDec;

    assign rotL = {rot[MW-5:0], rot[MW-1 -: 4]};
    assign rotR = {rot[3:0], rot[MW-1:4]};

    // Explicit wrap so non-power-of-2 message lengths stay modulo MSG_NIBBLES.
    assign offInc = (offset == OFF_MAX) ? '0 : offset + 1'b1;
    assign offDec = (offset == '0) ? OFF_MAX : offset - 1'b1;

    assign dataBus  = rot[MW-1 -: 4*WIN_NIBBLES];
    assign dbgState = state;

    always_ff @(posedge clk3hz) begin
        if (!rst || load) begin
            rot      <= msg_in;
            modeQ    <= mode;
            offset   <= '0;
            state    <= FWD;
            dwellCnt <= '0;
            edge_p   <= 1'b0;
        end else if (run) begin
            edge_p <= 1'b0;
            if (!modeQ) begin
                if (!dir) begin
                    rot    <= rotL;
                    offset <= offInc;
                    edge_p <= (offInc == '0);
                end else begin
                    rot    <= rotR;
                    offset <= offDec;
                    edge_p <= (offDec == '0);
                end
            end else if (LAST_OFF != '0) begin
                // Window as wide as the message: nothing to bounce, stay in FWD.
                case (state)
                    FWD: begin
                        rot    <= rotL;
                        offset <= offInc;
                        if (offInc == LAST_OFF) begin
                            edge_p <= 1'b1;
                            state  <= (DWELL == 0) ? BACK : DW_END;
                        end
                    end
                    DW_END: begin
                        if (dwellCnt == DW_LAST) begin
                            dwellCnt <= '0;
                            state    <= BACK;
                        end else begin
                            dwellCnt <= dwellCnt + 1'b1;
                        end
                    end
                    BACK: begin
                        rot    <= rotR;
                        offset <= offDec;
                        if (offDec == '0) begin
                            edge_p <= 1'b1;
                            state  <= (DWELL == 0) ? FWD : DW_START;
                        end
                    end
                    DW_START: begin
                        if (dwellCnt == DW_LAST) begin
                            dwellCnt <= '0;
                            state    <= FWD;
                        end else begin
                            dwellCnt <= dwellCnt + 1'b1;
                        end
                    end
                    default: state <= FWD;
                endcase
            end
        end else begin
            edge_p <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msg_scroller.sv
module tb_msg_scroller;

    logic        clk3hz = 1'b0;
    logic        rst, load, run, mode, dir;
    logic [31:0] msgIn;
    logic [15:0] dataBus;
    logic [2:0]  offset;
    logic        edgeP;
    logic [1:0]  dbgState;

    // Degenerate build: window as wide as the message, bounce mode.
    logic        loadFull, runFull, modeFull;
    logic [31:0] msgFull;
    logic [31:0] dataBusFull;
    logic [2:0]  offsetFull;
    logic        edgeFull;
    logic [1:0]  stateFull;
    int          edgeFullCnt = 0;
    logic        fullArmed = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [15:0] winTab [8] = '{16'h4120, 16'h1209, 16'h2098, 16'h0987,
                                16'h9876, 16'h8764, 16'h7641, 16'h6412};

    always #5 clk3hz = ~clk3hz;

    msg_scroller #(.MSG_NIBBLES(8), .WIN_NIBBLES(4), .DWELL(2)) u_dut (
        .clk3hz  (clk3hz),
        .rst     (rst),
        .msg_in  (msgIn),
        .load    (load),
        .run     (run),
        .mode    (mode),
        .dir     (dir),
        .dataBus (dataBus),
        .offset  (offset),
        .edge_p  (edgeP),
        .dbgState(dbgState)
    );

    msg_scroller #(.MSG_NIBBLES(8), .WIN_NIBBLES(8), .DWELL(2)) u_full (
        .clk3hz  (clk3hz),
        .rst     (rst),
        .msg_in  (msgFull),
        .load    (loadFull),
        .run     (runFull),
        .mode    (modeFull),
        .dir     (dir),
        .dataBus (dataBusFull),
        .offset  (offsetFull),
        .edge_p  (edgeFull),
        .dbgState(stateFull)
    );

    always @(negedge clk3hz) begin
        if (fullArmed && edgeFull !== 1'b0) edgeFullCnt++;
    end

    task automatic step();
        @(posedge clk3hz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input int off, input logic e, input logic [1:0] st);
        check({tag, ".data"},  {16'h0, dataBus},  {16'h0, winTab[off]});
        check({tag, ".off"},   {29'h0, offset},   32'(off));
        check({tag, ".edge"},  {31'h0, edgeP},    {31'h0, e});
        check({tag, ".state"}, {30'h0, dbgState}, {30'h0, st});
    endtask

    task automatic checkFull(input string tag);
        check({tag, ".fdata"},  dataBusFull,        32'h41209876);
        check({tag, ".foff"},   {29'h0, offsetFull}, 32'h0);
        check({tag, ".fedge"},  {31'h0, edgeFull},   32'h0);
        check({tag, ".fstate"}, {30'h0, stateFull},  32'h0);
    endtask

    task automatic doReset(input logic m, input logic d);
        rst   = 1'b0;
        load  = 1'b0;
        run   = 1'b1;
        mode  = m;
        dir   = d;
        msgIn = 32'h41209876;
        step();
        rst = 1'b1;
        checkOut("reset", 0, 1'b0, 2'd0);
    endtask

    initial begin
        int bOff [13] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0, 1};
        logic bEdge [13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic [1:0] bSt [13] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 0, 0};

        rst = 1'b0; load = 1'b0; run = 1'b0; mode = 1'b0; dir = 1'b0;
        msgIn = 32'h41209876;
        msgFull = 32'h41209876; loadFull = 1'b0; runFull = 1'b1; modeFull = 1'b1;

        // 1: reset, then circular left for a full turn
        doReset(1'b0, 1'b0);
        fullArmed = 1'b1;
        checkFull("full0");
        for (int k = 1; k <= 8; k++) exp_q.push_back({16'h0, winTab[k % 8]});
        for (int k = 1; k <= 8; k++) begin
            logic [31:0] e;
            step();
            e = exp_q.pop_front();
            check("circL.data", {16'h0, dataBus}, e);
            check("circL.off",  {29'h0, offset},  32'(k % 8));
            check("circL.edge", {31'h0, edgeP},   (k == 8) ? 32'h1 : 32'h0);
        end
        step();
        check("circL.edgeOnce", {31'h0, edgeP}, 32'h0);

        // 2: circular right, then flip direction mid-run
        doReset(1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            checkOut("circR", (8 - k) % 8, (k == 8), 2'd0);
        end
        step();
        step();
        checkOut("circR.pre", 6, 1'b0, 2'd0);
        dir = 1'b0;
        step();
        checkOut("circR.flip", 7, 1'b0, 2'd0);

        // 3: bounce; dir must be ignored
        doReset(1'b1, 1'b1);
        for (int k = 0; k < 13; k++) begin
            step();
            checkOut("bounce", bOff[k], bEdge[k], bSt[k]);
        end
        checkFull("full1");

        // 4: run gating mid-scroll and during dwell
        doReset(1'b1, 1'b0);
        step();
        step();
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOut("gateMid", 2, 1'b0, 2'd0);
        end
        run = 1'b1;
        step(); checkOut("resume1", 3, 1'b0, 2'd0);
        step(); checkOut("resume2", 4, 1'b1, 2'd1);
        step(); checkOut("dwell1",  4, 1'b0, 2'd1);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOut("gateDwell", 4, 1'b0, 2'd1);
        end
        run = 1'b1;
        step(); checkOut("dwell2", 4, 1'b0, 2'd2);
        step(); checkOut("back1",  3, 1'b0, 2'd2);

        // 5: load during DW_END switches to circular with a new message
        doReset(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step();
        checkOut("preLoad", 4, 1'b1, 2'd1);
        load = 1'b1; msgIn = 32'hDEADBEEF; mode = 1'b0;
        step();
        check("load.data",  {16'h0, dataBus},  32'h0000DEAD);
        check("load.off",   {29'h0, offset},   32'h0);
        check("load.edge",  {31'h0, edgeP},    32'h0);
        check("load.state", {30'h0, dbgState}, 32'h0);
        load = 1'b0; mode = 1'b1; dir = 1'b1;
        step();
        check("modeNoLoad.data", {16'h0, dataBus}, 32'h0000FDEA);
        check("modeNoLoad.off",  {29'h0, offset},  32'h7);

        // 6: reset during BACK overrides load and run
        doReset(1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step();
        checkOut("preRst", 3, 1'b0, 2'd2);
        rst = 1'b0; load = 1'b1; run = 1'b1; mode = 1'b0; msgIn = 32'h41209876;
        step();
        checkOut("midRst", 0, 1'b0, 2'd0);
        rst = 1'b1; load = 1'b0;
        step();
        checkOut("afterRst", 1, 1'b0, 2'd0);
        checkFull("full2");
        check("full.edgeCount", 32'(edgeFullCnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_scroller.md
# msg_scroller

Parametrised successor to the fixed 32-bit/16-bit nibble rotator that drives the display data bus. It holds a message of `MSG_NIBBLES` hex digits and presents a `WIN_NIBBLES`-digit window on `dataBus`, one nibble step per enabled `clk3hz` edge. Two scroll modes are supported:

- circular rotation, in either direction;
- bounce (ping-pong), with a programmable dwell at each end.

It sits between the ID/message source and the 7-segment scan driver.

## Interface
Parameters:
- `MSG_NIBBLES`, default 8: message length in nibbles; ≥ 2.
- `WIN_NIBBLES`, default 4: visible window in nibbles; 1 ≤ `WIN_NIBBLES` ≤ `MSG_NIBBLES`.
- `DWELL`, default 2: enabled cycles held at each end in bounce mode; 0 means no hold.
- `OFFW`, default `$clog2(MSG_NIBBLES)` (minimum 1): width of `offset`.

Ports:
- `clk3hz`, input, 1: scroll clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `msg_in`, input, `4*MSG_NIBBLES`: message; nibble `MSG_NIBBLES-1` is the MSB nibble and is shown first.
- `load`, input, 1: synchronous reload of `msg_in` and `mode`.
- `run`, input, 1: scroll enable; low freezes all state.
- `mode`, input, 1: 0 = circular, 1 = bounce; latched only at reset/load.
- `dir`, input, 1: circular-mode direction (0 = left, 1 = right); sampled live; ignored in bounce mode.
- `dataBus`, output, `4*WIN_NIBBLES`: top `WIN_NIBBLES` nibbles of the rotation register.
- `offset`, output, `OFFW`: current net left-rotation count.
- `edge_p`, output, 1: one-cycle pulse marking a wrap or end position.

## Operation
- **State.** The block holds a rotation register `rot` (`4*MSG_NIBBLES` bits), `mode_q`, `offset`, a bounce FSM state, a dwell counter and `edge_p`. All outputs are registered.
- **Priority.** `!rst` > `load` > `run` > hold.
- **Reset and load** have identical effect:
  - `rot` ← `msg_in`, `mode_q` ← `mode`, `offset` ← 0;
  - FSM ← `FWD`, dwell counter ← 0, `edge_p` ← 0.
- **Rotation operations:**
  - Left: `rot` ← {`rot[4*MSG_NIBBLES-5:0]`, `rot[4*MSG_NIBBLES-1 -: 4]`}.
  - Right: `rot` ← {`rot[3:0]`, `rot[4*MSG_NIBBLES-1:4]`}.
- **Circular mode** (`mode_q`=0), on each `run` cycle:
  - Rotate one nibble: left if `dir`=0, right if `dir`=1.
  - `offset` steps +1 for left, −1 for right, modulo `MSG_NIBBLES`. Wrap is explicit: `MSG_NIBBLES-1`→0 and 0→`MSG_NIBBLES-1`; this holds for non-power-of-2 lengths.
  - `edge_p`=1 in the cycle after any step whose new `offset` is 0, else 0.
- **Bounce mode** (`mode_q`=1), with `LAST` = `MSG_NIBBLES-WIN_NIBBLES`. FSM states `FWD`, `DW_END`, `BACK`, `DW_START`, evaluated only on `run` cycles:
  - `FWD`: rotate left, `offset`+1. When the new `offset` = `LAST`, pulse `edge_p` and go to `DW_END` (or directly to `BACK` if `DWELL`=0).
  - `DW_END`: hold `rot`; count `DWELL` run cycles; then go to `BACK`.
  - `BACK`: rotate right, `offset`−1. When the new `offset` = 0, pulse `edge_p` and go to `DW_START` (or directly to `FWD` if `DWELL`=0).
  - `DW_START`: hold `DWELL` run cycles; then go to `FWD`.
  - `LAST`=0 (`WIN_NIBBLES`=`MSG_NIBBLES`): no rotation ever, `edge_p` stays 0, FSM stays in `FWD`.
- **`run` low:** `rot`, `offset`, FSM and dwell counter all hold; `edge_p` = 0.
- **`mode`/`dir` changes:** a change of `mode` without `load` has no effect. A change of `dir` takes effect on the next `run` cycle.

## Timing
- **Reset values:**
  - `dataBus` = `msg_in[4*MSG_NIBBLES-1 -: 4*WIN_NIBBLES]` as sampled at the reset edge;
  - `offset` = 0; `edge_p` = 0.
- **Latency:**
  - one `clk3hz` edge from `run`=1 to the new `dataBus`;
  - `edge_p` is coincident with the `dataBus` value that is at the end/wrap position.
- **Load:** `load` during dwell or mid-scroll aborts immediately. The next cycle shows the new message at `offset` 0 with FSM in `FWD`.
- **Reset mid-operation:** same result as load, regardless of `run` and `load`.
- **Bounce period:** `2*LAST + 2*DWELL` run cycles.

## Test plan
All scenarios use `MSG_NIBBLES`=8, `WIN_NIBBLES`=4, `DWELL`=2, `msg_in`=0x41209876.

1. **Reset, then circular left.** Reset with `mode`=0, `dir`=0, `run`=1.
   - Expect `dataBus` 0x4120, then 0x1209, then 0x2098.
   - After 8 steps `dataBus`=0x4120, `offset`=0, and `edge_p` high for exactly that cycle.
2. **Circular right.** `dir`=1 from reset.
   - Expect `dataBus` 0x6412, `offset`=7 after 1 step; `edge_p` only at the 8th step.
   - Flip `dir` mid-run: `offset` reverses on the next edge.
3. **Bounce.** `mode`=1.
   - `offset` sequence 0,1,2,3,4, with `dataBus`=0x9876 and `edge_p`=1 at `offset` 4.
   - Hold 0x9876 for 2 more cycles, then 0x0987 (`offset` 3), ... back to 0x4120 with `edge_p`=1.
   - Hold 2 cycles, then 0x1209.
4. **Run gating.** Drop `run` for 5 cycles, once mid-scroll and once during dwell.
   - `dataBus`, `offset` and the remaining dwell count are unchanged; `edge_p` stays 0.
   - The sequence resumes exactly where it paused.
5. **Load mid-operation.** In bounce `DW_END`, pulse `load` with `msg_in`=0xDEADBEEF and `mode`=0.
   - Next cycle: `dataBus`=0xDEAD, `offset`=0, circular mode.
   - Toggling `mode` without `load` has no effect.
6. **Reset mid-run and degenerate window.**
   - `rst`=0 during `BACK`: next cycle shows the reset values.
   - Separate build with `WIN_NIBBLES`=8, bounce mode: `dataBus` is constant 0x41209876 and `edge_p` is never asserted.
